// File: rtl/mul_div_pkg.sv
// Shared definitions for the M-extension execute unit: widths, op codes,
// FSM state encoding, divide special-case constants and op decode helpers.
package mul_div_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 5;

  localparam logic [OP_W-1:0] MD_MUL    = 4'b0011;
  localparam logic [OP_W-1:0] MD_MULH   = 4'b0101;
  localparam logic [OP_W-1:0] MD_MULHSU = 4'b0110;
  localparam logic [OP_W-1:0] MD_MULHU  = 4'b0111;
  localparam logic [OP_W-1:0] MD_DIV    = 4'b1001;
  localparam logic [OP_W-1:0] MD_DIVU   = 4'b1011;
  localparam logic [OP_W-1:0] MD_REM    = 4'b1101;
  localparam logic [OP_W-1:0] MD_REMU   = 4'b1111;

  localparam logic [XLEN-1:0] DIV0_QUO = '1;
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_t;

  // True for the eight M-extension codes; everything else is a no-op.
  function automatic logic is_legal(input logic [OP_W-1:0] op);
    case (op)
      MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
      MD_DIV, MD_DIVU, MD_REM, MD_REMU: is_legal = 1'b1;
      default:                          is_legal = 1'b0;
    endcase
  endfunction

  // Multiply codes are the legal codes with the top bit clear.
  function automatic logic is_mul(input logic [OP_W-1:0] op);
    is_mul = ~op[OP_W-1];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Decoder-to-execute bus for the mul/div unit.
//   master: drives start, mulDiv_op, rs1, rs2, flush; receives stall, done, result
//   slave : the execute unit side
interface mul_div_unit_if;
  import mul_div_pkg::*;

  logic            start;
  logic [OP_W-1:0] mulDiv_op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, mulDiv_op, rs1, rs2, flush,
    input  stall, done, result
  );

  modport slave (
    input  start, mulDiv_op, rs1, rs2, flush,
    output stall, done, result
  );

endinterface

// File: rtl/div_iter.sv
// Radix-2 restoring divider datapath on unsigned magnitudes.
//   clk, rst          : clock, synchronous active-high reset
//   load              : capture dividend/divisor, clear remainder and counter
//   step              : perform one shift/trial-subtract iteration
//   dividend, divisor : unsigned operands sampled on load
//   quo, rem          : running quotient / remainder
//   last_c            : current step is the final (32nd) iteration
module div_iter
  import mul_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem,
  output logic            last_c
);

  logic [XLEN-1:0]  dvs_q;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]    rem_sh;
  logic [XLEN-1:0]  diff;
  logic             ge;

  // Shifted partial remainder can reach 33 bits, so compare at full width;
  // when it is >= divisor the true difference always fits in XLEN bits.
  always_comb begin
    rem_sh = {rem, quo[XLEN-1]};
    ge     = rem_sh >= {1'b0, dvs_q};
    diff   = rem_sh[XLEN-1:0] - dvs_q;
    last_c = cnt == CNT_W'(XLEN - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvs_q <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
    end else if (load) begin
      dvs_q <= divisor;
      rem   <= '0;
      quo   <= dividend;
      cnt   <= '0;
    end else if (step) begin
      rem   <= ge ? diff : rem_sh[XLEN-1:0];
      quo   <= {quo[XLEN-2:0], ge};
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32 M-extension execute unit: 2-cycle multiply, 34-cycle
// restoring divide, 1-cycle divide special cases.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of mul_div_unit_if (start/op/operands/flush in,
//              combinational stall, one-cycle done pulse, held result out)
module mul_div_unit
  import mul_div_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mul_div_unit_if.slave bus
);

  localparam int unsigned PW = 2 * XLEN;

  state_t            state, state_nxt;
  logic [OP_W-1:0]   op_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic              quo_neg_q, rem_neg_q;
  logic [XLEN-1:0]   result_q, res_nxt;
  logic              done_q;

  logic              accept_c, signed_in, rem_in, special_c;
  logic [XLEN-1:0]   spec_val, mag_a, mag_b;
  logic              div_load, div_step, div_last_c;
  logic [XLEN-1:0]   div_quo, div_rem;
  logic signed [XLEN:0] a_ext, b_ext;
  logic signed [PW-1:0] prod;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // Accept decode plus divide operand conditioning on the incoming op.
  always_comb begin
    accept_c  = bus.start && is_legal(bus.mulDiv_op) && !bus.flush &&
                (state == ST_IDLE || state == ST_DONE);
    signed_in = (bus.mulDiv_op == MD_DIV) || (bus.mulDiv_op == MD_REM);
    rem_in    = (bus.mulDiv_op == MD_REM) || (bus.mulDiv_op == MD_REMU);
    mag_a     = (signed_in && bus.rs1[XLEN-1]) ? -bus.rs1 : bus.rs1;
    mag_b     = (signed_in && bus.rs2[XLEN-1]) ? -bus.rs2 : bus.rs2;
    special_c = 1'b0;
    spec_val  = '0;
    if (bus.rs2 == '0) begin
      special_c = 1'b1;
      spec_val  = rem_in ? bus.rs1 : DIV0_QUO;
    end else if (signed_in && bus.rs1 == INT_MIN && bus.rs2 == '1) begin
      special_c = 1'b1;
      spec_val  = rem_in ? '0 : INT_MIN;
    end
  end

  // 33x33 signed product; sign extension of each operand depends on the op.
  always_comb begin
    a_ext = {((op_q == MD_MULH) || (op_q == MD_MULHSU)) & a_q[XLEN-1], a_q};
    b_ext = {(op_q == MD_MULH) & b_q[XLEN-1], b_q};
    prod  = PW'(a_ext) * PW'(b_ext);
  end

  // Sign fix-up of the unsigned divider results.
  always_comb begin
    quo_fix = quo_neg_q ? -div_quo : div_quo;
    rem_fix = rem_neg_q ? -div_rem : div_rem;
  end

  div_iter u_div_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quo      (div_quo),
    .rem      (div_rem),
    .last_c   (div_last_c)
  );

  // Next-state, result select and divider control.
  always_comb begin
    state_nxt = state;
    res_nxt   = result_q;
    div_load  = 1'b0;
    div_step  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_nxt = ST_IDLE;
        if (accept_c) begin
          if (is_mul(bus.mulDiv_op)) begin
            state_nxt = ST_MUL;
          end else if (special_c) begin
            state_nxt = ST_DONE;
            res_nxt   = spec_val;
          end else begin
            state_nxt = ST_DIV;
            div_load  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        state_nxt = ST_DONE;
        res_nxt   = (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (div_last_c) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        state_nxt = ST_DONE;
        res_nxt   = ((op_q == MD_REM) || (op_q == MD_REMU)) ? rem_fix : quo_fix;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (bus.flush) state_nxt = ST_IDLE;
  end

  // State, latched op/operands, result and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= state_nxt == ST_DONE;
      if (state_nxt == ST_DONE) result_q <= res_nxt;
      if (accept_c) begin
        op_q      <= bus.mulDiv_op;
        a_q       <= bus.rs1;
        b_q       <= bus.rs2;
        quo_neg_q <= signed_in && (bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1]);
        rem_neg_q <= signed_in && bus.rs1[XLEN-1];
      end
    end
  end

  assign bus.stall  = (state == ST_IDLE && accept_c) || state == ST_MUL ||
                      state == ST_DIV || state == ST_FIX;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a per-cycle behavioural model of
// done/stall/result plus directed operations with hand-computed results.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst;
  int   nchk = 0;
  int   nerr = 0;

  mul_div_unit_if bus();

  mul_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] OP_MUL    = 4'b0011;
  localparam logic [3:0] OP_MULH   = 4'b0101;
  localparam logic [3:0] OP_MULHSU = 4'b0110;
  localparam logic [3:0] OP_MULHU  = 4'b0111;
  localparam logic [3:0] OP_DIV    = 4'b1001;
  localparam logic [3:0] OP_DIVU   = 4'b1011;
  localparam logic [3:0] OP_REM    = 4'b1101;
  localparam logic [3:0] OP_REMU   = 4'b1111;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [3:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // Architectural result of an M-extension op, using plain integer arithmetic.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          p;
    longint unsigned pu;
    int              sa;
    int              sb;
    logic [63:0]     bz;
    sa = a;
    sb = b;
    bz = {32'b0, b};
    case (op)
      OP_MUL:    begin pu = 64'(a) * 64'(b); return pu[31:0]; end
      OP_MULH:   begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      OP_MULHSU: begin p = longint'(sa) * longint'(bz); return p[63:32]; end
      OP_MULHU:  begin pu = 64'(a) * 64'(b); return pu[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      OP_REMU: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Cycles from accept edge to done.
  function automatic int latency(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU}) return 2;
    if (b == 0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 34;
  endfunction

  // Behavioural model: pending-op countdown updated on every rising edge.
  bit          m_valid = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_res = '0;
  bit          m_done = 1'b0;
  logic [31:0] m_result = '0;

  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      pend_cnt = 0;
      m_done   = 1'b0;
      m_result = '0;
      m_valid  = 1'b1;
    end else if (bus.flush) begin
      pend_cnt = 0;
      m_done   = 1'b0;
    end else begin
      acc    = bus.start && legal(bus.mulDiv_op) && pend_cnt == 0;
      m_done = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          m_done   = 1'b1;
          m_result = pend_res;
        end
      end
      if (acc) begin
        pend_res = model(bus.mulDiv_op, bus.rs1, bus.rs2);
        pend_cnt = latency(bus.mulDiv_op, bus.rs1, bus.rs2) - 1;
        if (pend_cnt == 0) begin
          m_done   = 1'b1;
          m_result = pend_res;
        end
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    bit exp_stall;
    if (m_valid) begin
      exp_stall = (pend_cnt > 0) ||
                  (bus.start && legal(bus.mulDiv_op) && !bus.flush && !m_done);
      chk("model done", 32'(bus.done), 32'(m_done));
      chk("model stall", 32'(bus.stall), 32'(exp_stall));
      chk("model result", bus.result, m_result);
    end
  end

  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat);
    int k;
    bit seen;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mulDiv_op = op; bus.rs1 = a; bus.rs2 = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mulDiv_op = 4'($urandom);
    bus.rs1 = $urandom; bus.rs2 = $urandom;
    seen = 1'b0;
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({nm, " done seen"}, 32'(seen), 32'd1);
    chk({nm, " latency"}, 32'(k), 32'(exp_lat));
    chk({nm, " result"}, bus.result, exp_res);
  endtask

  task automatic no_done_window(input string nm, input int cycles);
    bit seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    bus.start = 1'b0; bus.mulDiv_op = '0; bus.rs1 = '0; bus.rs2 = '0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset result", bus.result, 32'h0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset stall", 32'(bus.stall), 32'd0);

    run_op("MUL 7*-3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2);

    // Illegal code: no stall, no done, result held.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mulDiv_op = 4'b0001; bus.rs1 = 32'd5; bus.rs2 = 32'd6;
    @(negedge clk);
    chk("illegal stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1 bus.start = 1'b0;
    no_done_window("illegal no done", 5);
    chk("illegal result held", bus.result, 32'hFFFF_FFEB);

    run_op("MULHU max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    run_op("MULHSU -1*2", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 2);
    run_op("MULH min*min", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
    run_op("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    run_op("REM 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    run_op("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run_op("REMU 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
    run_op("DIVU x/0", OP_DIVU, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("DIV x/0", OP_DIV, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("REM 5/0", OP_REM, 32'd5, 32'd0, 32'd5, 1);
    run_op("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    // Back-to-back: MUL accepted in the DONE cycle of a DIVU.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mulDiv_op = OP_DIVU; bus.rs1 = 32'd100; bus.rs2 = 32'd7;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    chk("b2b first done", 32'(bus.done), 32'd1);
    chk("b2b first result", bus.result, 32'd14);
    bus.start = 1'b1; bus.mulDiv_op = OP_MUL; bus.rs1 = 32'd3; bus.rs2 = 32'd5;
    @(posedge clk); #1 bus.start = 1'b0;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    chk("b2b gap", 32'(k), 32'd2);
    chk("b2b second result", bus.result, 32'd15);

    // Flush at cycle 10 of a divide.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mulDiv_op = OP_DIVU; bus.rs1 = 32'd1000; bus.rs2 = 32'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    chk("flush stall", 32'(bus.stall), 32'd0);
    chk("flush done", 32'(bus.done), 32'd0);
    no_done_window("flush no done", 40);
    chk("flush result held", bus.result, 32'd15);

    // Simultaneous start and flush is not accepted.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.flush = 1'b1;
    bus.mulDiv_op = OP_DIVU; bus.rs1 = 32'd9; bus.rs2 = 32'd3;
    @(negedge clk);
    chk("start+flush stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1 bus.start = 1'b0; bus.flush = 1'b0;
    chk("start+flush idle", 32'(bus.stall), 32'd0);
    no_done_window("start+flush no done", 40);
    chk("start+flush result", bus.result, 32'd15);

    // Reset at cycle 20 of a divide, then a fresh divide.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.mulDiv_op = OP_DIV; bus.rs1 = 32'd1000; bus.rs2 = 32'd7;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midreset stall", 32'(bus.stall), 32'd0);
    chk("midreset done", 32'(bus.done), 32'd0);
    chk("midreset result", bus.result, 32'h0);
    run_op("DIVU 9/3", OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative M-extension execute unit for the RV32 core; it sits directly downstream of the instruction decoder and consumes its 4-bit `mulDiv_op` code with the two register operands. It computes MUL/MULH/MULHSU/MULHU in 2 cycles and DIV/DIVU/REM/REMU with a 32-step radix-2 restoring divider. A stall output holds the pipeline until `done`.

## Interface
- `XLEN`, 32: operand and result width. Only 32 is supported.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `start`  in  1  the op is valid this cycle.
- `mulDiv_op`  in  4  op code: 0011 MUL, 0101 MULH, 0110 MULHSU, 0111 MULHU, 1001 DIV, 1011 DIVU, 1101 REM, 1111 REMU. All other codes are "no op".
- `rs1`  in  XLEN  dividend / multiplicand.
- `rs2`  in  XLEN  divisor / multiplier.
- `flush`  in  1  abort the in-flight op (trap or branch redirect).
- `stall`  out  1  combinational; holds upstream stages.
- `done`  out  1  result valid. One-cycle pulse.
- `result`  out  XLEN  registered result. Held until the next `done`.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- **Accept.** An op is accepted when `start=1`, `mulDiv_op` is legal, `flush=0`, and the state is IDLE or DONE.
  - Back-to-back ops are allowed from DONE.
  - On accept, the unit latches the op, `rs1` and `rs2`.
  - `start` with an illegal code is ignored: no stall, no state change.
- **MUL path.**
  - Accept → MUL → DONE.
  - In MUL, the 33×33 signed product is registered. rs1 is sign-extended for MULH and MULHSU, otherwise zero-extended. rs2 is sign-extended for MULH only.
  - MUL returns product[31:0]. The other multiply ops return product[63:32].
- **DIV path.**
  - Signed ops (DIV, REM) take operand magnitudes and record the quotient sign (rs1[31]^rs2[31]) and the remainder sign (rs1[31]).
  - DIV runs 32 iterations with a 5-bit counter 0..31. Each iteration: shift {rem,quo} left by 1, trial-subtract the divisor, keep the difference if it is non-negative, and set quo[0].
  - After count 31 the unit goes to FIX. FIX applies the recorded signs, then goes to DONE.
- **Special cases.** These bypass DIV/FIX and go straight from accept to DONE.
  - Divide by zero: quotient = 0xFFFFFFFF (all unsigned and signed cases); remainder = rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- **DONE.** `done=1` and `result` is loaded on entry. The next state is IDLE unless a new op is accepted.
- **stall** = (accept condition true in IDLE) | state∈{MUL,DIV,FIX}. `stall` is 0 in DONE, so the consumer captures `result` while `done=1`.
- **Flush.**
  - At the next edge: state → IDLE, `done` stays 0, `result` is unchanged.
  - `flush` wins over a simultaneous `start`.
  - `flush` in DONE still lets that cycle's `done=1` stand; it was already asserted.
- **Reset.** On the next edge: state IDLE, counter 0, `result`=0, `done`=0. `stall`=0 after reset, including when reset hits mid-division.

## Timing
- Accept edge = cycle 0.
- Multiply: MUL in cycle 1, `done` in cycle 2. Latency 2.
- Divide: DIV in cycles 1–32, FIX in cycle 33, `done` in cycle 34. Latency 34.
- Special divide: `done` in cycle 1.
- `stall` is high from the accept cycle through the cycle before `done`.
- Throughput: a new op can be accepted in the DONE cycle, so there are no bubble cycles between ops.
- `rs1`, `rs2` and `mulDiv_op` are not sampled after accept; they may change freely.

## Structure
- Package `mul_div_pkg` holds:
  - the op-code localparams (MD_MUL … MD_REMU);
  - the state enum;
  - the special-case constants (DIV0_QUO = all ones, INT_MIN).
- Sub-module `div_iter` is the restoring-divider datapath (remainder/quotient registers, counter, trial subtractor) with `load`/`step` inputs.
- Top-level FSM, multiplier and sign fix-up stay in `mul_div_unit`.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD → `done` at cycle 2, `result`=0xFFFFFFEB. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → quotient 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14 with `done` exactly at cycle 34 and `stall` high in cycles 0–33.
- DIVU x/0 → 0xFFFFFFFF at cycle 1. REM 5/0 → 5. DIV 0x80000000/−1 → 0x80000000. REM of the same operands → 0.
- Back-to-back: accept MUL in the DONE cycle of a DIV → both `done` pulses occur, the second 2 cycles after the first.
- Flush at cycle 10 of a DIV → IDLE next cycle, no `done`, `result` holds its previous value. A simultaneous start+flush is not accepted.
- Reset asserted at cycle 20 of a DIV → `stall`=0, `done`=0, `result`=0 after the edge. A fresh DIVU 9/3 afterwards gives 3.
